fir_mac: RTL and testbench

Multiply-accumulate sequencer sitting directly downstream of the sample shift register in the FIR datapath.
- On each start pulse (issued together with nowa_shift), walks the tap address 0..TAPS-1.
- Reads one delayed sample and one coefficient per cycle, multiplies and accumulates them.
- Rounds and saturates the sum to a Q15 output sample with a one-cycle valid pulse.
- Drives the shift register's read address and the coefficient memory's read address.

---
 rtl/fir_pkg.sv | 29 ++
 rtl/fir_round_sat.sv | 39 +++
 rtl/fir_mac.sv | 109 ++++++++++
 tb/tb_fir_mac.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared constants, types and state encoding for the FIR MAC sequencer
//
// Purpose : single source of widths and types used by fir_mac and fir_round_sat.
// Contents: TAPS/ADDR_W/DATA_W/COEF_W/ACC_W/FRAC constants, sample_t, coef_t,
//           acc_t, prod_t typedefs and the mac_state_t sequencer states.
package fir_pkg;

   localparam int TAPS   = 32;
   localparam int ADDR_W = 5;
   localparam int DATA_W = 16;
   localparam int COEF_W = 16;
   localparam int PROD_W = DATA_W + COEF_W;
   // Wide enough for TAPS full-scale products, so the running sum never wraps.
   localparam int ACC_W  = DATA_W + COEF_W + ADDR_W;
   localparam int FRAC   = 15;

   typedef logic signed [DATA_W-1:0] sample_t;
   typedef logic signed [COEF_W-1:0] coef_t;
   typedef logic signed [PROD_W-1:0] prod_t;
   typedef logic signed [ACC_W-1:0]  acc_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MAC   = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } mac_state_t;

endpackage

// File: rtl/fir_round_sat.sv
// rtl/fir_round_sat.sv - round-half-up and Q15 saturation of the MAC accumulator
//
// Purpose : converts the wide accumulator into one Q15 output sample.
// Ports   : i_acc    in  ACC_W   signed accumulator value
//           o_result out DATA_W  rounded, saturated sample
//           o_sat    out 1       result was clamped to the Q15 range
module fir_round_sat
   import fir_pkg::*;
(
   input  acc_t    i_acc,
   output sample_t o_result,
   output logic    o_sat
);

   localparam acc_t ROUND_BIAS = acc_t'(1) <<< (FRAC - 1);
   localparam acc_t MAX_V      = acc_t'((2 ** (DATA_W - 1)) - 1);
   localparam acc_t MIN_V      = acc_t'(-(2 ** (DATA_W - 1)));

   acc_t w_biased;
   acc_t w_shifted;

   // Bias plus arithmetic shift gives round-half-up for both signs; the bias
   // cannot overflow because the accumulator has headroom above TAPS products.
   assign w_biased  = i_acc + ROUND_BIAS;
   assign w_shifted = w_biased >>> FRAC;

   always_comb begin
      o_sat    = 1'b0;
      o_result = w_shifted[DATA_W-1:0];
      if (w_shifted > MAX_V) begin
         o_sat    = 1'b1;
         o_result = {1'b0, {(DATA_W-1){1'b1}}};
      end else if (w_shifted < MIN_V) begin
         o_sat    = 1'b1;
         o_result = {1'b1, {(DATA_W-1){1'b0}}};
      end
   end

endmodule

// File: rtl/fir_mac.sv
// rtl/fir_mac.sv - tap-serial multiply-accumulate sequencer for the FIR datapath
//
// Purpose : on start, walks taps 0..TAPS-1, accumulates sample*coef and emits a
//           rounded, saturated Q15 result with a one-cycle valid pulse.
// Ports   : clk          in  1       rising-edge clock
//           rst          in  1       synchronous active-high reset
//           start        in  1       request one output sample (ignored while busy)
//           probka_in    in  DATA_W  delayed sample at adres (combinational read)
//           coef_in      in  COEF_W  coefficient at adres (combinational read)
//           adres        out ADDR_W  tap index to shift register and coefficient memory
//           busy         out 1       computation in progress
//           wynik        out DATA_W  rounded/saturated result, held until next DONE
//           wynik_valid  out 1       one-cycle pulse marking a new wynik
//           overflow     out 1       wynik was saturated
module fir_mac
   import fir_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic signed [DATA_W-1:0] probka_in,
   input  logic signed [COEF_W-1:0] coef_in,
   output logic        [ADDR_W-1:0] adres,
   output logic                     busy,
   output logic signed [DATA_W-1:0] wynik,
   output logic                     wynik_valid,
   output logic                     overflow
);

   localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(TAPS - 1);

   mac_state_t        r_state;
   logic [ADDR_W-1:0] r_cnt;
   acc_t              r_acc;
   prod_t             r_p;
   sample_t           r_wynik;
   logic              r_valid;
   logic              r_ovf;

   prod_t   w_prod;
   acc_t    w_p_ext;
   sample_t w_round;
   logic    w_sat;

   assign w_prod  = prod_t'(probka_in) * prod_t'(coef_in);
   assign w_p_ext = acc_t'(r_p);

   fir_round_sat u_round_sat (
      .i_acc    (r_acc),
      .o_result (w_round),
      .o_sat    (w_sat)
   );

   assign adres       = (r_state == MAC) ? r_cnt : '0;
   assign busy        = (r_state != IDLE);
   assign wynik       = r_wynik;
   assign wynik_valid = r_valid;
   assign overflow    = r_ovf;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_acc   <= '0;
         r_p     <= '0;
         r_wynik <= '0;
         r_valid <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_acc   <= '0;
                  r_cnt   <= '0;
                  r_state <= MAC;
               end
            end
            MAC: begin
               // The product is registered, so the sum lags the address by one
               // cycle: tap 0's product is first added while tap 1 is read.
               r_p <= w_prod;
               if (r_cnt != '0) begin
                  r_acc <= r_acc + w_p_ext;
               end
               if (r_cnt == LAST_TAP) begin
                  r_state <= FLUSH;
               end else begin
                  r_cnt <= r_cnt + ADDR_W'(1);
               end
            end
            FLUSH: begin
               r_acc   <= r_acc + w_p_ext;
               r_state <= DONE;
            end
            DONE: begin
               r_wynik <= w_round;
               r_ovf   <= w_sat;
               r_valid <= 1'b1;
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fir_mac.sv
// tb/tb_fir_mac.sv - self-checking bench for fir_mac
module tb_fir_mac;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic signed [15:0] probka_in;
   logic signed [15:0] coef_in;
   logic [4:0]  adres;
   logic        busy;
   logic [15:0] wynik;
   logic        wynik_valid;
   logic        overflow;

   logic signed [15:0] smp [32];
   logic signed [15:0] cf  [32];

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   assign probka_in = smp[adres];
   assign coef_in   = cf[adres];

   fir_mac dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .probka_in   (probka_in),
      .coef_in     (coef_in),
      .adres       (adres),
      .busy        (busy),
      .wynik       (wynik),
      .wynik_valid (wynik_valid),
      .overflow    (overflow)
   );

   typedef struct {
      logic [15:0] s;
      logic [15:0] c;
      bit          imp;
      logic [15:0] ew;
      bit          eo;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Dot product over all taps, then round-half-up and clamp to Q15.
   function automatic void ref_out(output logic [15:0] w, output logic o);
      longint acc;
      longint r;
      acc = 0;
      for (int i = 0; i < 32; i++) acc += longint'(smp[i]) * longint'(cf[i]);
      r = (acc + 64'sd16384) >>> 15;
      if (r > 32767) begin
         w = 16'h7FFF; o = 1'b1;
      end else if (r < -32768) begin
         w = 16'h8000; o = 1'b1;
      end else begin
         w = r[15:0]; o = 1'b0;
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issues one start and watches `limit` edges. Edge count e is measured from
   // the edge that samples start. x1/x2 pulse start again mid-run; chain
   // re-issues start in the cycle of the first valid.
   task automatic run(input int x1, input int x2, input bit chain, input int limit,
                      output int nval, output int lat1, output int lat2,
                      output logic [15:0] w1, output logic [15:0] w2,
                      output logic o1, output logic o2, output bit adr_ok);
      int e;
      nval = 0; lat1 = -1; lat2 = -1;
      w1 = '0; w2 = '0; o1 = 1'b0; o2 = 1'b0; adr_ok = 1'b1;
      start = 1'b1;
      tick();
      e = 1;
      while (1) begin
         if (e <= 32 && adres !== 5'(e - 1)) adr_ok = 1'b0;
         start = (e == x1) || (e == x2);
         if (wynik_valid === 1'b1) begin
            nval++;
            if (nval == 1) begin
               lat1 = e; w1 = wynik; o1 = overflow;
               if (chain) start = 1'b1;
            end else if (nval == 2) begin
               lat2 = e - lat1; w2 = wynik; o2 = overflow;
            end
         end
         if (e >= limit) break;
         tick();
         e++;
      end
      start = 1'b0;
   endtask

   task automatic fill(input logic [15:0] s, input logic [15:0] c, input bit imp);
      for (int i = 0; i < 32; i++) begin
         smp[i] = imp ? ((i == 0) ? s : 16'h0000) : s;
         cf[i]  = imp ? ((i == 0) ? c : 16'h1234) : c;
      end
   endtask

   task automatic fill_random();
      for (int i = 0; i < 32; i++) begin
         smp[i] = 16'($urandom);
         cf[i]  = 16'($urandom_range(0, 4095)) - 16'sd2048;
      end
   endtask

   initial begin
      vec_t tbl[9];
      int nval, lat1, lat2, e, vcnt;
      logic [15:0] w1, w2, ew;
      logic o1, o2, eo;
      bit adr_ok;

      tbl[0] = '{16'h0100, 16'h4000, 1'b0, 16'h1000, 1'b0};
      tbl[1] = '{16'h7FFF, 16'h7FFF, 1'b1, 16'h7FFE, 1'b0};
      tbl[2] = '{16'h7FFF, 16'h7FFF, 1'b0, 16'h7FFF, 1'b1};
      tbl[3] = '{16'h8000, 16'h7FFF, 1'b0, 16'h8000, 1'b1};
      tbl[4] = '{16'hFF00, 16'h4000, 1'b0, 16'hF000, 1'b0};
      tbl[5] = '{16'h0001, 16'h0200, 1'b0, 16'h0001, 1'b0};
      tbl[6] = '{16'hFFFF, 16'h0200, 1'b0, 16'h0000, 1'b0};
      tbl[7] = '{16'h8000, 16'h8000, 1'b0, 16'h7FFF, 1'b1};
      tbl[8] = '{16'hFFFF, 16'h0201, 1'b0, 16'hFFFF, 1'b0};

      rst = 1'b1;
      start = 1'b0;
      fill(16'h0000, 16'h0000, 1'b0);
      repeat (3) tick();
      chk("reset_busy", busy, 0);
      chk("reset_adres", adres, 0);
      chk("reset_wynik", wynik, 0);
      chk("reset_valid", wynik_valid, 0);
      chk("reset_ovf", overflow, 0);
      rst = 1'b0;
      tick();

      for (int i = 0; i < 9; i++) begin
         fill(tbl[i].s, tbl[i].c, tbl[i].imp);
         run(-1, -1, 1'b0, 80, nval, lat1, lat2, w1, w2, o1, o2, adr_ok);
         chk($sformatf("vec%0d_wynik", i), w1, tbl[i].ew);
         chk($sformatf("vec%0d_ovf", i), o1, tbl[i].eo);
         chk($sformatf("vec%0d_nvalid", i), nval, 1);
         chk($sformatf("vec%0d_latency", i), lat1, 35);
         chk($sformatf("vec%0d_adres_seq", i), adr_ok, 1);
         chk($sformatf("vec%0d_hold", i), wynik, tbl[i].ew);
      end

      // Extra start pulses while busy are ignored.
      fill_random();
      ref_out(ew, eo);
      run(5, 20, 1'b0, 80, nval, lat1, lat2, w1, w2, o1, o2, adr_ok);
      chk("busy_start_nvalid", nval, 1);
      chk("busy_start_wynik", w1, ew);
      chk("busy_start_ovf", o1, eo);
      chk("busy_start_latency", lat1, 35);

      // Start in the valid cycle is accepted.
      run(-1, -1, 1'b1, 110, nval, lat1, lat2, w1, w2, o1, o2, adr_ok);
      chk("chain_nvalid", nval, 2);
      chk("chain_latency2", lat2, 35);
      chk("chain_wynik2", w2, ew);

      // Reset in MAC cycle 10 aborts the run.
      fill(16'h0100, 16'h4000, 1'b0);
      run(-1, -1, 1'b0, 40, nval, lat1, lat2, w1, w2, o1, o2, adr_ok);
      fill_random();
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 1; k < 10; k++) tick();
      chk("abort_busy_before", busy, 1);
      rst = 1'b1;
      tick();
      chk("abort_rst_busy", busy, 0);
      chk("abort_rst_adres", adres, 0);
      chk("abort_rst_wynik", wynik, 0);
      chk("abort_rst_valid", wynik_valid, 0);
      chk("abort_rst_ovf", overflow, 0);
      tick();
      rst = 1'b0;
      vcnt = 0;
      for (int k = 0; k < 50; k++) begin
         tick();
         if (wynik_valid === 1'b1) vcnt++;
      end
      chk("abort_no_valid", vcnt, 0);
      ref_out(ew, eo);
      run(-1, -1, 1'b0, 40, nval, lat1, lat2, w1, w2, o1, o2, adr_ok);
      chk("after_rst_wynik", w1, ew);
      chk("after_rst_ovf", o1, eo);
      chk("after_rst_latency", lat1, 35);

      // rst and start together: rst wins.
      rst = 1'b1;
      start = 1'b1;
      tick();
      rst = 1'b0;
      start = 1'b0;
      chk("rst_start_busy", busy, 0);
      tick();
      chk("rst_start_busy2", busy, 0);
      repeat (40) tick();

      // Back-to-back with shifting samples.
      fill_random();
      for (int k = 0; k < 8; k++) begin
         for (int i = 31; i > 0; i--) smp[i] = smp[i-1];
         smp[0] = 16'($urandom);
         ref_out(ew, eo);
         start = 1'b1;
         tick();
         start = 1'b0;
         e = 1;
         while (wynik_valid !== 1'b1 && e < 40) begin
            tick();
            e++;
         end
         chk($sformatf("b2b%0d_valid", k), wynik_valid, 1);
         chk($sformatf("b2b%0d_latency", k), e, 35);
         chk($sformatf("b2b%0d_wynik", k), wynik, ew);
         chk($sformatf("b2b%0d_ovf", k), overflow, eo);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
